// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds PC, fetches one word per retire via req/ack, selects next PC.
// Build option: define IFU_ALIGN_CHECK_EN to trap misaligned jr targets to EXC_VECTOR (adds misalign output).
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef IFU_ALIGN_CHECK_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcsource,
  input  logic [31:0] ra,
  input  logic        adv,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        inst_valid
`ifdef IFU_ALIGN_CHECK_EN
  , output logic      misalign
`endif
);

  typedef enum logic [1:0] {
    ST_RST   = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg;
  logic        inst_valid_reg;
  logic        load_inst;
  logic        retire;
  logic        misalign_next;
  logic [31:0] branch_off;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_RST;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RST:   state_next = ST_FETCH;
      ST_FETCH: if (imem_ack) state_next = ST_HOLD;
      ST_HOLD:  if (adv) state_next = ST_FETCH;
      default:  state_next = ST_RST;
    endcase
  end

  // Output / control decode
  always_comb begin
    imem_req  = (state_reg == ST_FETCH);
    load_inst = (state_reg == ST_FETCH) && imem_ack;
    retire    = (state_reg == ST_HOLD) && adv;
  end

  assign pc4 = pc_reg + 32'd4;

  always_comb begin
    branch_off    = {{14{inst_reg[15]}}, inst_reg[15:0], 2'b00};
    pc_next       = pc4;
    misalign_next = 1'b0;
    case (pcsource)
      2'b00: pc_next = pc4;
      2'b01: pc_next = pc4 + branch_off;
      2'b10: begin
`ifdef IFU_ALIGN_CHECK_EN
        if (ra[1:0] != 2'b00) begin
          pc_next       = EXC_VECTOR;
          misalign_next = 1'b1;
        end else begin
          pc_next = ra;
        end
`else
        // Low bits of a misaligned target are dropped silently
        pc_next = ra & 32'hFFFF_FFFC;
`endif
      end
      default: pc_next = {pc4[31:28], inst_reg[25:0], 2'b00};
    endcase
  end

  // Datapath registers; ack is only honoured while fetching
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg         <= RESET_PC;
      inst_reg       <= 32'h0;
      inst_valid_reg <= 1'b0;
    end else if (load_inst) begin
      inst_reg       <= imem_rdata;
      inst_valid_reg <= 1'b1;
    end else if (retire) begin
      pc_reg         <= pc_next;
      inst_valid_reg <= 1'b0;
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  logic misalign_reg;
  always_ff @(posedge clk) begin
    if (rst) misalign_reg <= 1'b0;
    else     misalign_reg <= retire && misalign_next;
  end
  assign misalign = misalign_reg;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_next;
`endif

  assign imem_addr  = pc_reg;
  assign pc         = pc_reg;
  assign inst       = inst_reg;
  assign op         = inst_reg[31:26];
  assign func       = inst_reg[5:0];
  assign inst_valid = inst_valid_reg;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: stimulus queues expected fetch addresses and held
// instructions, a negedge monitor pops and compares when req or inst_valid rises.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] ra = 32'h0;
  logic        adv = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc, pc4, inst;
  logic [5:0]  op, func;
  logic        inst_valid;
`ifdef IFU_ALIGN_CHECK_EN
  logic        misalign;
  localparam logic [31:0] MIS_ADDR = 32'h0000_0180;
`else
  localparam logic [31:0] MIS_ADDR = 32'h0000_0010;
`endif

  ifetch_unit dut (
    .clk(clk), .rst(rst), .pcsource(pcsource), .ra(ra), .adv(adv),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .pc4(pc4), .inst(inst), .op(op),
    .func(func), .inst_valid(inst_valid)
`ifdef IFU_ALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } hold_t;

  logic [31:0] req_q[$];
  hold_t       hold_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] exp_addr;
  hold_t       exp_hold;

  always @(negedge clk) begin
    if (imem_req === 1'b1 && !prev_req) begin
      if (req_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
      end else begin
        exp_addr = req_q.pop_front();
        check32("req_addr", imem_addr, exp_addr);
        $display("req   addr=%h expected=%h", imem_addr, exp_addr);
      end
    end
    if (inst_valid === 1'b1 && !prev_valid) begin
      if (hold_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got inst %h expected no instruction", inst);
      end else begin
        exp_hold = hold_q.pop_front();
        check32("hold_pc", pc, exp_hold.pc);
        check32("hold_inst", inst, exp_hold.inst);
        check32("hold_pc4", pc4, exp_hold.pc + 32'd4);
        check32("hold_op", {26'b0, op}, {26'b0, exp_hold.inst[31:26]});
        check32("hold_func", {26'b0, func}, {26'b0, exp_hold.inst[5:0]});
        $display("inst  pc=%h inst=%h op=%h func=%h pc4=%h", pc, inst, op, func, pc4);
      end
    end
    prev_req   <= (imem_req === 1'b1);
    prev_valid <= (inst_valid === 1'b1);
  end

  // Called at a negedge; completes a fetch of addr returning data after waits stall cycles
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int waits);
    int n;
    n = 0;
    hold_q.push_back('{pc: addr, inst: data});
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1("req_seen", imem_req, 1'b1);
    for (int i = 0; i < waits; i++) begin
      adv = 1'b1;  // must be ignored while fetching
      check32("wait_addr", imem_addr, addr);
      check1("wait_valid", inst_valid, 1'b0);
      check1("wait_req", imem_req, 1'b1);
      @(negedge clk);
    end
    adv = 1'b0;
    check32("ack_addr", imem_addr, addr);
    imem_ack = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    check1("valid_after_ack", inst_valid, 1'b1);
    check1("req_after_ack", imem_req, 1'b0);
  endtask

  task automatic retire(input logic [1:0] sel, input logic [31:0] rval, input logic [31:0] next);
    req_q.push_back(next);
    pcsource = sel;
    ra = rval;
    adv = 1'b1;
    @(negedge clk);
    adv = 1'b0;
    pcsource = ~sel;
    ra = 32'hDEAD_0001;
    check1("valid_drop", inst_valid, 1'b0);
    check32("next_pc", pc, next);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check32("rst_pc", pc, 32'h0);
    check32("rst_inst", inst, 32'h0);
    check1("rst_valid", inst_valid, 1'b0);
    check1("rst_req", imem_req, 1'b0);
    check32("rst_opfunc", {20'b0, op, func}, 32'h0);
`ifdef IFU_ALIGN_CHECK_EN
    check1("rst_misalign", misalign, 1'b0);
`endif
    req_q.push_back(32'h0);
    rst = 1'b0;
    @(negedge clk);
    check1("req_after_reset", imem_req, 1'b1);
    check32("addr_after_reset", imem_addr, 32'h0);

    fetch(32'h0000_0000, 32'h2008_0005, 0);
    check32("first_op", {26'b0, op}, 32'h08);
    check32("first_pc4", pc4, 32'h4);

    retire(2'b00, 32'h0, 32'h0000_0004);
    fetch(32'h0000_0004, 32'h0800_0040, 3);
    retire(2'b11, 32'h0, 32'h0000_0100);
    fetch(32'h0000_0100, 32'h1000_FFFE, 0);
    retire(2'b01, 32'h0, 32'h0000_00FC);
    fetch(32'h0000_00FC, 32'h0000_0008, 1);
    retire(2'b10, 32'h9000_0010, 32'h9000_0010);
    fetch(32'h9000_0010, 32'h0C00_0040, 0);
    check32("jal_pc4", pc4, 32'h9000_0014);
    retire(2'b11, 32'h0, 32'h9000_0100);
    fetch(32'h9000_0100, 32'h0000_0008, 0);
    retire(2'b10, 32'h0040_0020, 32'h0040_0020);
    fetch(32'h0040_0020, 32'h0000_0008, 0);
    retire(2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 2);

    // Hold with adv low; a stray ack must not overwrite the held word
    for (int i = 0; i < 3; i++) begin
      imem_ack = (i == 1);
      imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      check32("hold_keep_inst", inst, 32'h0000_0000);
      check32("hold_keep_pc", pc, 32'hFFFF_FFFC);
      check1("hold_keep_valid", inst_valid, 1'b1);
      check1("hold_no_req", imem_req, 1'b0);
    end
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    check32("wrap_pc4", pc4, 32'h0);
    retire(2'b00, 32'h0, 32'h0000_0000);

    fetch(32'h0000_0000, 32'h0000_0008, 0);
    retire(2'b10, 32'h0000_0013, MIS_ADDR);
`ifdef IFU_ALIGN_CHECK_EN
    check1("misalign_pulse", misalign, 1'b1);
    @(negedge clk);
    check1("misalign_clear", misalign, 1'b0);
`endif
    fetch(MIS_ADDR, 32'h2008_0005, 0);
    retire(2'b00, 32'h0, MIS_ADDR + 32'd4);

    // Reset while a fetch is pending; ack arrives during RST
    rst = 1'b1;
    @(negedge clk);
    check1("midrst_req", imem_req, 1'b0);
    check1("midrst_valid", inst_valid, 1'b0);
    check32("midrst_pc", pc, 32'h0);
    req_q.push_back(32'h0);
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    check1("midrst_ignored_valid", inst_valid, 1'b0);
    check32("midrst_ignored_inst", inst, 32'h0);
    check1("refetch_req", imem_req, 1'b1);
    check32("refetch_addr", imem_addr, 32'h0);
    fetch(32'h0000_0000, 32'h0000_0020, 1);

    repeat (2) @(negedge clk);
    check32("req_q_empty", req_q.size(), 32'd0);
    check32("hold_q_empty", hold_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage of the single-cycle MIPS CPU. Holds the PC and fetches one instruction word per retire over a req/ack instruction-memory handshake. Presents op/func/instruction to the control unit. Consumes the control unit's pcsource, and the register-file rs value for jr, to select the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
EXC_VECTOR, 32'h0000_0180, redirect target for a misaligned jr (optional feature only).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
pcsource  in  2  next-PC select from control unit: 00 pc+4, 01 branch, 10 jr (ra), 11 jump/jal
ra  in  32  rs register value, the jr target
adv  in  1  retire strobe from decode/writeback; current instruction done, fetch next
imem_req  out  1  instruction-memory request
imem_addr  out  32  word address of the request (= pc)
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  32  instruction word, valid with imem_ack
pc  out  32  address of the held instruction
pc4  out  32  pc + 4 (jal link value)
inst  out  32  held instruction word
op  out  6  inst[31:26]
func  out  6  inst[5:0]
inst_valid  out  1  inst is valid and may be decoded/executed

Behaviour:
- States: RST, FETCH, HOLD.
- Reset (rst=1 at an edge): state<=RST, pc<=RESET_PC, inst<=32'h0, inst_valid<=0, imem_req<=0. Reset overrides adv/ack in the same cycle.
- RST: imem_req=0. Next cycle go to FETCH unconditionally.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until ack.
  - On the imem_ack edge: inst<=imem_rdata, inst_valid<=1, state<=HOLD.
  - Ack may arrive in the same cycle req first rises (zero-wait memory).
  - adv is ignored in FETCH.
- HOLD:
  - imem_req=0, inst_valid=1.
  - adv=0: hold everything.
  - adv=1: pc<=next_pc, inst_valid<=0, state<=FETCH.
- imem_ack outside FETCH is ignored. Data from a fetch aborted by reset is never captured.
- next_pc, computed from the held inst:
  - 00: pc4.
  - 01: pc4 + ({{14{inst[15]}}, inst[15:0], 2'b00}).
  - 10: ra.
  - 11: {pc4[31:28], inst[25:0], 2'b00}.
- Arithmetic: all 32-bit, modulo 2^32. Carry out is discarded; 32'hFFFF_FFFC + 4 = 32'h0.
- pcsource is sampled only on the adv edge. Upstream (z-dependent branch decision) must be settled at that edge.
- Latency:
  - adv at edge N → imem_req high in cycle N+1.
  - Zero-wait ack → inst_valid at N+2.
  - One instruction per 2 cycles minimum; each memory wait cycle adds one.
- op/func are combinational slices of inst and are 0 after reset.
- pc4 is combinational from pc.

Optional Feature:
IFU_ALIGN_CHECK_EN
- Defined:
  - Adds output misalign (1 bit).
  - On adv with pcsource=10 and ra[1:0]!=0: pc<=EXC_VECTOR and misalign<=1 for exactly one cycle (cycle after the adv edge).
  - misalign resets to 0.
- Undefined:
  - No misalign port.
  - jr loads {ra[31:2], 2'b00}; low bits are silently dropped.

Test Plan:
- Reset, then zero-wait memory → imem_req=1, imem_addr=0 one cycle after rst falls; ack with 32'h2008_0005 → next cycle inst_valid=1, op=6'h08, pc4=4.
- Sequential: pcsource=00, adv pulses, ack delayed 3 cycles → imem_addr holds 0x4 for 4 cycles; inst_valid=0 throughout, then 1.
- Branch: pc=0x100, inst[15:0]=16'hFFFE, pcsource=01, adv → next imem_addr=0x0FC.
- Jump/jal: pc=0x9000_0010, inst[25:0]=26'h0000040, pcsource=11 → next addr 0x9000_0100, pc4 was 0x9000_0014.
- jr and wrap: ra=0x0040_0020, pcsource=10 → next addr 0x0040_0020. pc=0xFFFF_FFFC, pcsource=00 → next addr 0x0.
- Reset mid-fetch: rst during FETCH while ack pending, ack arriving during RST → ack ignored, inst_valid=0, refetch from RESET_PC. With IFU_ALIGN_CHECK_EN: ra=0x13, pcsource=10 → addr 0x180, misalign high for one cycle.
